// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI sync decoder: decoder FSM states and error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hdmi_pkg;

    // Decoder states: wait for a first vsync, vertical blank, horizontal blank, active pixels
    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_BLANK  = 2'd2,
        ST_ACTIVE = 2'd3
    } dec_state_t;

    // Error codes reported on err_code_o, listed from highest to lowest reporting priority
    localparam logic [1:0] ERR_VDE_SYNC = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;
    localparam logic [1:0] ERR_WIDTH    = 2'd1;
    localparam logic [1:0] ERR_HEIGHT   = 2'd2;

endpackage

// File: rtl/hdmi_geom_checker.sv
// Frame geometry tracker: per-frame reference width, width/height mismatch detection, lock counter.
// Latency: mismatch flags are combinational from the strobes; meas_*/locked update on the strobe edge.
// Backpressure: none; strobes are consumed in the cycle they arrive.
module hdmi_geom_checker #(
    parameter int XWidth     = 12,
    parameter int YWidth     = 12,
    parameter int LockFrames = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_begin,
    input  logic              line_end,
    input  logic [XWidth-1:0] width,
    input  logic              frame_end,
    input  logic [YWidth-1:0] height,
    input  logic              ext_err,
    output logic              width_mis,
    output logic              height_mis,
    output logic [XWidth-1:0] meas_width,
    output logic [YWidth-1:0] meas_height,
    output logic              locked
);

    // LockFrames is at most 15, so four bits always hold the saturated count
    localparam int CntW = 4;
    localparam logic [CntW-1:0] LockCnt = CntW'(LockFrames);

    logic [XWidth-1:0] ref_width;
    logic              first_line;
    logic              frame_bad;
    logic              has_ref;
    logic [CntW-1:0]   stable_cnt;
    logic [CntW-1:0]   stable_next;
    logic [XWidth-1:0] frame_width;
    logic              frame_ok;
    logic              frame_good;
    logic              same_geom;
    logic              err_any;

    // Mismatch detection and next value of the stable-frame counter
    always_comb begin
        width_mis   = line_end & ~first_line & (width != ref_width);
        // A frame closed by vsync during its first line has not latched a reference yet
        frame_width = (line_end & first_line) ? width : ref_width;
        // A frame with no lines at all carries no geometry and is ignored
        frame_ok    = frame_end & (height != '0);
        height_mis  = frame_ok & has_ref & (height != meas_height);
        err_any     = ext_err | width_mis | height_mis;
        frame_good  = frame_ok & ~frame_bad & ~ext_err & ~width_mis;
        same_geom   = (frame_width == meas_width) && (height == meas_height);
        stable_next = stable_cnt;
        if (err_any) begin
            stable_next = '0;
        end else if (frame_good) begin
            if (!has_ref || same_geom) begin
                if (stable_cnt != LockCnt) begin
                    stable_next = stable_cnt + 1'b1;
                end
            end else begin
                // New geometry without an error: this frame becomes the first stable one
                stable_next = CntW'(1);
            end
        end
    end

    // Reference, frame quality, published geometry and lock state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ref_width   <= '0;
            first_line  <= 1'b0;
            frame_bad   <= 1'b0;
            has_ref     <= 1'b0;
            stable_cnt  <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            locked      <= 1'b0;
        end else begin
            stable_cnt <= stable_next;
            locked     <= (stable_next == LockCnt);
            if (frame_begin) begin
                first_line <= 1'b1;
                frame_bad  <= 1'b0;
            end else begin
                if (line_end) begin
                    first_line <= 1'b0;
                    if (first_line) begin
                        ref_width <= width;
                    end
                end
                if (ext_err | width_mis) begin
                    frame_bad <= 1'b1;
                end
            end
            if (frame_good) begin
                meas_width  <= frame_width;
                meas_height <= height;
                has_ref     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdmi_sync_decoder.sv
// Recovers pixel coordinates from vsync/hsync/vde, measures geometry, reports lock and errors.
// Latency: 1 cycle from a sampled vde_i to pixel_valid_o; all outputs registered.
// Backpressure: none; every input sample is consumed, the stream cannot be stalled.
module hdmi_sync_decoder
    import hdmi_pkg::*;
#(
    parameter int XWidth     = 12,
    parameter int YWidth     = 12,
    parameter int LockFrames = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vsync_i,
    input  logic              hsync_i,
    input  logic              vde_i,
    output logic              pixel_valid_o,
    output logic [XWidth-1:0] x_o,
    output logic [YWidth-1:0] y_o,
    output logic              frame_start_o,
    output logic              line_end_o,
    output logic [XWidth-1:0] meas_width_o,
    output logic [YWidth-1:0] meas_height_o,
    output logic              locked_o,
    output logic              error_o,
    output logic [1:0]        err_code_o
);

    localparam logic [XWidth-1:0] XMax = '1;
    localparam logic [YWidth-1:0] YMax = '1;

    dec_state_t        state;
    logic [XWidth-1:0] x_cnt;
    logic [YWidth-1:0] y_cnt;
    logic              synced;

    logic              pix_ok;
    logic              err_sync;
    logic              pixel;
    logic              line_end;
    logic              frame_end;
    logic              frame_begin;
    logic              x_ovf;
    logic              y_ovf;
    logic              ext_err;
    logic [XWidth-1:0] x_pix;
    logic [YWidth-1:0] y_next;
    logic              width_mis;
    logic              height_mis;

    // Classify the current input sample against the decoder state
    always_comb begin
        pix_ok      = vde_i & ~hsync_i & ~vsync_i;
        // Nothing is reported until the first vertical blank has completed
        err_sync    = vde_i & (hsync_i | vsync_i) & synced;
        pixel       = 1'b0;
        line_end    = 1'b0;
        frame_end   = 1'b0;
        frame_begin = 1'b0;
        x_ovf       = 1'b0;
        y_ovf       = 1'b0;
        x_pix       = x_cnt;
        case (state)
            ST_VBLANK: frame_begin = ~vsync_i;
            ST_BLANK: begin
                if (vsync_i) begin
                    frame_end = 1'b1;
                end else if (pix_ok) begin
                    pixel = 1'b1;
                    x_pix = '0;
                end
            end
            ST_ACTIVE: begin
                if (pix_ok) begin
                    pixel = 1'b1;
                    x_ovf = (x_cnt == XMax - 1'b1);
                end else begin
                    // vsync arriving mid-line closes both the line and the frame
                    line_end  = 1'b1;
                    frame_end = vsync_i;
                    y_ovf     = (y_cnt == YMax - 1'b1);
                end
            end
            default: ;
        endcase
        y_next = y_cnt;
        if (line_end && (y_cnt != YMax)) begin
            y_next = y_cnt + 1'b1;
        end
        ext_err = err_sync | x_ovf | y_ovf;
    end

    // Decoder FSM, coordinate counters and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_SEEK;
            x_cnt         <= '0;
            y_cnt         <= '0;
            synced        <= 1'b0;
            pixel_valid_o <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            frame_start_o <= 1'b0;
            line_end_o    <= 1'b0;
            error_o       <= 1'b0;
            err_code_o    <= '0;
        end else begin
            pixel_valid_o <= pixel;
            frame_start_o <= pixel && (state == ST_BLANK) && (y_cnt == '0);
            line_end_o    <= line_end;
            if (pixel) begin
                x_o <= x_pix;
                y_o <= y_cnt;
            end
            error_o <= ext_err | width_mis | height_mis;
            if (err_sync) begin
                err_code_o <= ERR_VDE_SYNC;
            end else if (x_ovf | y_ovf) begin
                err_code_o <= ERR_OVERFLOW;
            end else if (width_mis) begin
                err_code_o <= ERR_WIDTH;
            end else if (height_mis) begin
                err_code_o <= ERR_HEIGHT;
            end else begin
                err_code_o <= '0;
            end
            case (state)
                ST_SEEK: begin
                    if (vsync_i) begin
                        state <= ST_VBLANK;
                    end
                end
                ST_VBLANK: begin
                    if (!vsync_i) begin
                        state  <= ST_BLANK;
                        x_cnt  <= '0;
                        y_cnt  <= '0;
                        synced <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (vsync_i) begin
                        state <= ST_VBLANK;
                    end else if (pix_ok) begin
                        state <= ST_ACTIVE;
                        x_cnt <= XWidth'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (pix_ok) begin
                        if (x_cnt != XMax) begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end else begin
                        y_cnt <= y_next;
                        state <= vsync_i ? ST_VBLANK : ST_BLANK;
                    end
                end
                default: state <= ST_SEEK;
            endcase
        end
    end

    hdmi_geom_checker #(
        .XWidth    (XWidth),
        .YWidth    (YWidth),
        .LockFrames(LockFrames)
    ) u_geom (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .frame_begin(frame_begin),
        .line_end   (line_end),
        .width      (x_cnt),
        .frame_end  (frame_end),
        .height     (y_next),
        .ext_err    (ext_err),
        .width_mis  (width_mis),
        .height_mis (height_mis),
        .meas_width (meas_width_o),
        .meas_height(meas_height_o),
        .locked     (locked_o)
    );

endmodule
